// File: rtl/regfile_pkg.sv
// Shared constants and a packed-port field helper for the multi-port register file.
// Field helper supports fields up to FIELD_MAX bits and buses up to BUS_MAX bits.
package regfile_pkg;

    localparam int XLEN_DEF  = 64;
    localparam int NREGS_DEF = 32;
    localparam int ZERO_REG  = 0;
    localparam int FIELD_MAX = 128;
    localparam int BUS_MAX   = 4 * FIELD_MAX;

    // Returns field k of a bus whose fields are 'width' bits wide, zero-extended to FIELD_MAX.
    function automatic logic [FIELD_MAX-1:0] port_field(
        input logic [BUS_MAX-1:0] bus,
        input int                 width,
        input int                 k
    );
        logic [BUS_MAX-1:0]   shifted;
        logic [FIELD_MAX-1:0] mask;
        shifted = bus >> (k * width);
        mask    = (FIELD_MAX'(1) << width) - FIELD_MAX'(1);
        return shifted[FIELD_MAX-1:0] & mask;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle between issue/writeback logic (master) and the register file (slave).
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    parameter int NWR   = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NWR-1:0]      we;
    logic [NWR*AW-1:0]   waddr;
    logic [NWR*XLEN-1:0] wdata;
    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      rvalid;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic                flush;
    logic [NREGS-1:0]    busy;

    modport master (
        output we, waddr, wdata, raddr, iss_en, iss_addr, flush,
        input  rdata, rvalid, busy
    );

    modport slave (
        input  we, waddr, wdata, raddr, iss_en, iss_addr, flush,
        output rdata, rvalid, busy
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: issue sets, writeback clears, flush clears all.
// Issue wins over a same-cycle writeback and survives a same-cycle flush.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int NWR   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_addr,
    input  logic [NWR-1:0]   we,
    input  logic [AW-1:0]    waddr [NWR],
    output logic [NREGS-1:0] busy
);

    logic [NREGS-1:0] pending_reg;
    logic [NREGS-1:0] pending_next;

    always_comb begin
        pending_next = pending_reg;
        if (flush) begin
            pending_next = '0;
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (we[k]) begin
                    pending_next[waddr[k]] = 1'b0;
                end
            end
        end
        if (iss_en && iss_addr != AW'(ZERO_REG)) begin
            pending_next[iss_addr] = 1'b1;
        end
        pending_next[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    assign busy = pending_reg;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port integer register file with RAW pending scoreboard.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    parameter int NWR   = 2
) (
    input logic          clk,
    input logic          rst,
    regfile_mp_if.slave  bus
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]  mem_reg   [NREGS];
    logic [AW-1:0]    waddr_arr [NWR];
    logic [XLEN-1:0]  wdata_arr [NWR];
    logic [NREGS-1:0] busy;

    genvar gi;
    generate
        for (gi = 0; gi < NWR; gi++) begin : g_wr_unpack
            assign waddr_arr[gi] = AW'(port_field(BUS_MAX'(bus.waddr), AW, gi));
            assign wdata_arr[gi] = XLEN'(port_field(BUS_MAX'(bus.wdata), XLEN, gi));
        end
    endgenerate

    // Later ports overwrite earlier ones, so the highest-index port wins a same-address conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (bus.we[k] && waddr_arr[k] != AW'(ZERO_REG)) begin
                    mem_reg[waddr_arr[k]] <= wdata_arr[k];
                end
            end
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NWR   (NWR),
        .AW    (AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .flush    (bus.flush),
        .iss_en   (bus.iss_en),
        .iss_addr (bus.iss_addr),
        .we       (bus.we),
        .waddr    (waddr_arr),
        .busy     (busy)
    );

    assign bus.busy = busy;

    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd_port
            logic [AW-1:0]   ra;
            logic [XLEN-1:0] rd;
            logic            rv;

            assign ra = AW'(port_field(BUS_MAX'(bus.raddr), AW, gi));

            always_comb begin
                rd = mem_reg[ra];
                rv = !busy[ra];
`ifdef REGFILE_BYPASS_EN
                // A writeback this cycle completes the pending producer, unless a new
                // producer for the same register is being issued right now.
                for (int k = 0; k < NWR; k++) begin
                    if (bus.we[k] && waddr_arr[k] == ra) begin
                        rd = wdata_arr[k];
                        rv = (bus.iss_en && bus.iss_addr == ra) ? !busy[ra] : 1'b1;
                    end
                end
`endif
                if (ra == AW'(ZERO_REG)) begin
                    rd = '0;
                    rv = 1'b1;
                end
            end

            assign bus.rdata[gi*XLEN +: XLEN] = rd;
            assign bus.rvalid[gi]             = rv;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised self-checking bench for regfile_mp against an architectural reference model.
module tb_regfile_mp;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) rf_if ();

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (rf_if)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // stimulus for the current cycle
    logic             rst_v;
    logic [1:0]       we_v;
    logic [4:0]       waddr_v [2];
    logic [63:0]      wdata_v [2];
    logic [4:0]       raddr_v [2];
    logic             iss_en_v;
    logic [4:0]       iss_addr_v;
    logic             flush_v;

    // architectural reference state
    logic [63:0] model_mem  [NREGS];
    logic        model_pend [NREGS];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] exp_rdata(input logic [4:0] a);
        logic [63:0] v;
        if (a == 5'd0) return 64'd0;
        v = model_mem[a];
`ifdef REGFILE_BYPASS_EN
        for (int k = 0; k < NWR; k++)
            if (we_v[k] && waddr_v[k] == a) v = wdata_v[k];
`endif
        return v;
    endfunction

    function automatic logic exp_rvalid(input logic [4:0] a);
        if (a == 5'd0) return 1'b1;
`ifdef REGFILE_BYPASS_EN
        for (int k = 0; k < NWR; k++)
            if (we_v[k] && waddr_v[k] == a)
                return (iss_en_v && iss_addr_v == a) ? !model_pend[a] : 1'b1;
`endif
        return !model_pend[a];
    endfunction

    function automatic logic [63:0] exp_busy();
        logic [63:0] b = '0;
        for (int r = 0; r < NREGS; r++) b[r] = model_pend[r];
        return b;
    endfunction

    task automatic idle();
        rst_v = 1'b0; we_v = '0; iss_en_v = 1'b0; iss_addr_v = '0; flush_v = 1'b0;
        for (int k = 0; k < 2; k++) begin
            waddr_v[k] = '0; wdata_v[k] = '0; raddr_v[k] = '0;
        end
    endtask

    // Drive this cycle's inputs, let them settle, compare against the model.
    task automatic apply();
        rst            = rst_v;
        rf_if.we       = we_v;
        rf_if.waddr    = {waddr_v[1], waddr_v[0]};
        rf_if.wdata    = {wdata_v[1], wdata_v[0]};
        rf_if.raddr    = {raddr_v[1], raddr_v[0]};
        rf_if.iss_en   = iss_en_v;
        rf_if.iss_addr = iss_addr_v;
        rf_if.flush    = flush_v;
        #1;
        $display("cyc %0d rst=%b we=%b wa=%0d/%0d ra=%0d/%0d iss=%b/%0d flush=%b",
                 cyc, rst_v, we_v, waddr_v[0], waddr_v[1], raddr_v[0], raddr_v[1],
                 iss_en_v, iss_addr_v, flush_v);
        for (int j = 0; j < NRD; j++) begin
            check($sformatf("rdata%0d", j), rf_if.rdata[j*XLEN +: XLEN], exp_rdata(raddr_v[j]));
            check($sformatf("rvalid%0d", j), 64'(rf_if.rvalid[j]), 64'(exp_rvalid(raddr_v[j])));
        end
        check("busy", 64'(rf_if.busy), exp_busy());
    endtask

    // Clock edge, then advance the model by the architectural rules.
    task automatic commit();
        logic np [NREGS];
        logic iss_hit, wr_hit;
        @(posedge clk);
        if (rst_v) begin
            for (int r = 0; r < NREGS; r++) begin
                model_mem[r] = '0; model_pend[r] = 1'b0;
            end
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                iss_hit = iss_en_v && iss_addr_v == 5'(r);
                wr_hit  = 1'b0;
                for (int k = 0; k < NWR; k++)
                    if (we_v[k] && waddr_v[k] == 5'(r)) wr_hit = 1'b1;
                if (r == 0)        np[r] = 1'b0;
                else if (iss_hit)  np[r] = 1'b1;
                else if (flush_v)  np[r] = 1'b0;
                else if (wr_hit)   np[r] = 1'b0;
                else               np[r] = model_pend[r];
            end
            for (int k = 0; k < NWR; k++)
                if (we_v[k] && waddr_v[k] != 5'd0) model_mem[waddr_v[k]] = wdata_v[k];
            for (int r = 0; r < NREGS; r++) model_pend[r] = np[r];
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic step();
        apply();
        commit();
    endtask

    function automatic logic [4:0] rand_addr();
        return ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
    endfunction

    initial begin
        idle();
        rst_v = 1'b1;
        rst = 1'b1;
        rf_if.we = '0; rf_if.waddr = '0; rf_if.wdata = '0; rf_if.raddr = '0;
        rf_if.iss_en = 1'b0; rf_if.iss_addr = '0; rf_if.flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int r = 0; r < NREGS; r++) begin
            model_mem[r] = '0; model_pend[r] = 1'b0;
        end

        // preload, pend a register, then reset
        idle(); we_v = 2'b11; waddr_v[0] = 5'd1; wdata_v[0] = 64'h1111; waddr_v[1] = 5'd2;
        wdata_v[1] = 64'h2222; iss_en_v = 1'b1; iss_addr_v = 5'd6; step();
        idle(); raddr_v[0] = 5'd1; raddr_v[1] = 5'd2; step();
        idle(); rst_v = 1'b1; we_v = 2'b01; waddr_v[0] = 5'd3; wdata_v[0] = 64'h3333;
        iss_en_v = 1'b1; iss_addr_v = 5'd8; flush_v = 1'b1; step();
        for (int a = 0; a < NREGS; a += 2) begin
            idle(); raddr_v[0] = 5'(a); raddr_v[1] = 5'(a + 1); step();
        end

        // x0 protection
        idle(); we_v = 2'b01; waddr_v[0] = 5'd0; wdata_v[0] = 64'hDEAD;
        iss_en_v = 1'b1; iss_addr_v = 5'd0; step();
        idle(); apply();
        check("x0_rdata", rf_if.rdata[63:0], 64'd0);
        check("x0_busy0", 64'(rf_if.busy[0]), 64'd0);
        commit();

        // dual-write conflict on register 5
        idle(); we_v = 2'b11; waddr_v[0] = 5'd5; waddr_v[1] = 5'd5;
        wdata_v[0] = 64'h11; wdata_v[1] = 64'h22; raddr_v[0] = 5'd5; step();
        idle(); raddr_v[0] = 5'd5; apply();
        check("dual_wr_r5", rf_if.rdata[63:0], 64'h22);
        commit();

        // scoreboard on register 7
        idle(); iss_en_v = 1'b1; iss_addr_v = 5'd7; step();
        idle(); raddr_v[1] = 5'd7; apply();
        check("r7_pending", 64'(rf_if.rvalid[1]), 64'd0);
        commit();
        idle(); we_v = 2'b10; waddr_v[1] = 5'd7; wdata_v[1] = 64'h99; raddr_v[0] = 5'd7; step();
        idle(); raddr_v[0] = 5'd7; apply();
        check("r7_valid", 64'(rf_if.rvalid[0]), 64'd1);
        check("r7_data", rf_if.rdata[63:0], 64'h99);
        commit();
        idle(); iss_en_v = 1'b1; iss_addr_v = 5'd7; step();
        idle(); iss_en_v = 1'b1; iss_addr_v = 5'd7; we_v = 2'b10; waddr_v[1] = 5'd7;
        wdata_v[1] = 64'h77; raddr_v[0] = 5'd7; step();
        idle(); raddr_v[0] = 5'd7; apply();
        check("r7_still_pend", 64'(rf_if.busy[7]), 64'd1);
        commit();

        // flush with a same-cycle issue
        foreach (raddr_v[j]) raddr_v[j] = '0;
        idle(); iss_en_v = 1'b1; iss_addr_v = 5'd3; step();
        idle(); iss_en_v = 1'b1; iss_addr_v = 5'd4; step();
        idle(); iss_en_v = 1'b1; iss_addr_v = 5'd9; step();
        idle(); flush_v = 1'b1; iss_en_v = 1'b1; iss_addr_v = 5'd12; step();
        idle(); apply();
        check("flush_busy", 64'(rf_if.busy), 64'h1000);
        commit();

        // write-to-read timing on register 10
        idle(); we_v = 2'b01; waddr_v[0] = 5'd10; wdata_v[0] = 64'h1234; step();
        idle(); we_v = 2'b01; waddr_v[0] = 5'd10; wdata_v[0] = 64'hABCD; raddr_v[0] = 5'd10; apply();
`ifdef REGFILE_BYPASS_EN
        check("byp_same_cyc", rf_if.rdata[63:0], 64'hABCD);
`else
        check("nobyp_same_cyc", rf_if.rdata[63:0], 64'h1234);
`endif
        commit();
        idle(); raddr_v[0] = 5'd10; apply();
        check("byp_next_cyc", rf_if.rdata[63:0], 64'hABCD);
        commit();

        // randomised traffic
        for (int n = 0; n < 400; n++) begin
            idle();
            rst_v      = ($urandom_range(0, 79) == 0);
            flush_v    = ($urandom_range(0, 19) == 0);
            we_v       = 2'($urandom_range(0, 3));
            iss_en_v   = ($urandom_range(0, 2) != 0);
            iss_addr_v = rand_addr();
            for (int k = 0; k < 2; k++) begin
                waddr_v[k] = rand_addr();
                wdata_v[k] = {$urandom, $urandom};
                raddr_v[k] = rand_addr();
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
